// File: rtl/wb_interconnect_arb_ctrl.sv
// Round-robin, cyc-locked Wishbone B3 arbiter: MASTERS masters share one slave port.
// Optional slave-response watchdog enabled with `define WB_ARB_TIMEOUT_EN.
module wb_interconnect_arb_ctrl #(
  parameter int MASTERS    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [MASTERS*ADDR_WIDTH-1:0]     m_adr_i,
  input  logic [MASTERS*DATA_WIDTH-1:0]     m_dat_i,
  input  logic [MASTERS*(DATA_WIDTH/8)-1:0] m_sel_i,
  input  logic [MASTERS-1:0]                m_we_i,
  input  logic [MASTERS-1:0]                m_cyc_i,
  input  logic [MASTERS-1:0]                m_stb_i,
  input  logic [MASTERS*3-1:0]              m_cti_i,
  input  logic [MASTERS*2-1:0]              m_bte_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [MASTERS-1:0]                m_ack_o,
  output logic [MASTERS-1:0]                m_err_o,
  output logic [MASTERS-1:0]                m_rty_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [DATA_WIDTH/8-1:0]           s_sel_o,
  output logic                              s_we_o,
  output logic [2:0]                        s_cti_o,
  output logic [1:0]                        s_bte_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  input  logic                              s_rty_i,
  output logic [MASTERS-1:0]                gnt_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

  state_t             state, state_nxt;
  logic [MASTERS-1:0] gnt, nxt_gnt;
  logic [IW-1:0]      gidx, idx;
  logic               found;
  logic               busy;
  logic               to_hit;

  always_comb begin
    gidx = '0;
    for (int k = 0; k < MASTERS; k++)
      if (gnt[k]) gidx = IW'(k);
  end

  // Search starts just above the holder and wraps, so the holder is checked last.
  always_comb begin
    nxt_gnt = gnt;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= MASTERS; i++) begin
      idx = IW'((32'(gidx) + 32'(i)) % MASTERS);
      if (!found && m_cyc_i[idx]) begin
        nxt_gnt      = '0;
        nxt_gnt[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || state != BUSY || s_ack_i || s_err_i || s_rty_i)
      cnt <= '0;
    else if (s_stb_o && cnt != TO_VAL)
      cnt <= cnt + 1'b1;
  end

  assign to_hit = busy && (cnt == TO_VAL);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|m_cyc_i) state_nxt = BUSY;
      BUSY: begin
        if (to_hit)              state_nxt = ABORT;
        else if (!m_cyc_i[gidx]) state_nxt = IDLE;
      end
      ABORT:   if (!m_cyc_i[gidx]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      gnt   <= MASTERS'(1);
    end else begin
      state <= state_nxt;
      if (state == IDLE) gnt <= nxt_gnt;
    end
  end

  // Reset gates the strobes and responses combinationally, not just at the next edge.
  assign busy    = (state == BUSY) && !rst_i;

  assign s_cyc_o = busy & m_cyc_i[gidx];
  assign s_stb_o = busy & m_stb_i[gidx];
  assign s_adr_o = m_adr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_dat_o = m_dat_i[gidx*DATA_WIDTH +: DATA_WIDTH];
  assign s_sel_o = m_sel_i[gidx*SW +: SW];
  assign s_we_o  = m_we_i[gidx];
  assign s_cti_o = m_cti_i[gidx*3 +: 3];
  assign s_bte_o = m_bte_i[gidx*2 +: 2];

  assign m_dat_o = s_dat_i;
  assign m_ack_o = gnt & {MASTERS{busy & s_ack_i}};
  assign m_err_o = gnt & {MASTERS{busy & (s_err_i | to_hit)}};
  assign m_rty_o = gnt & {MASTERS{busy & s_rty_i}};
  assign gnt_o   = gnt;

endmodule

// File: tb/tb_wb_interconnect_arb_ctrl.sv
// Directed bench for wb_interconnect_arb_ctrl with four masters; the watchdog
// section runs only when WB_ARB_TIMEOUT_EN is defined (TIMEOUT=8).
module tb_wb_interconnect_arb_ctrl;

  localparam int M  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [M*AW-1:0]   m_adr;
  logic [M*DW-1:0]   m_dat;
  logic [M*SW-1:0]   m_sel;
  logic [M-1:0]      m_we, m_cyc, m_stb;
  logic [M*3-1:0]    m_cti;
  logic [M*2-1:0]    m_bte;
  logic [DW-1:0]     m_rdat;
  logic [M-1:0]      m_ack, m_err, m_rty;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_wdat, s_rdat;
  logic [SW-1:0]     s_sel;
  logic              s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
  logic [2:0]        s_cti;
  logic [1:0]        s_bte;
  logic [M-1:0]      gnt;

  int n_chk  = 0;
  int n_fail = 0;

  wb_interconnect_arb_ctrl #(
    .MASTERS(M), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(8)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_rdat), .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_sel_o(s_sel), .s_we_o(s_we),
    .s_cti_o(s_cti), .s_bte_o(s_bte), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_dat_i(s_rdat), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .gnt_o(gnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [M-1:0] rr_exp [4];
  logic [2:0]   cti_seq [4];

  initial begin
    rr_exp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    cti_seq = '{3'b010, 3'b010, 3'b010, 3'b111};
    rst = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    m_cti = '0; m_bte = '0; s_rdat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    step; step;
    check("reset_gnt", gnt, 4'b0001);
    check("reset_scyc", s_cyc, 1'b0);

    // Single request from master 1
    rst = 1'b0;
    m_cyc = 4'b0010; m_stb = 4'b0010;
    m_adr[1*AW +: AW] = 16'h1234; m_dat[1*DW +: DW] = 16'h5678;
    m_sel[1*SW +: SW] = 2'b11; m_we[1] = 1'b1; m_bte[1*2 +: 2] = 2'b01;
    #1;
    check("m1_latency_scyc", s_cyc, 1'b0);
    step;
    check("m1_gnt", gnt, 4'b0010);
    check("m1_scyc", s_cyc, 1'b1);
    check("m1_sstb", s_stb, 1'b1);
    check("m1_adr", s_adr, 16'h1234);
    check("m1_wdat", s_wdat, 16'h5678);
    check("m1_sel", s_sel, 2'b11);
    check("m1_we", s_we, 1'b1);
    check("m1_bte", s_bte, 2'b01);
    s_ack = 1'b1; s_rdat = 16'hABCD; #1;
    check("m1_ack", m_ack, 4'b0010);
    check("m1_rdat", m_rdat, 16'hABCD);
    s_rty = 1'b1; #1;
    check("m1_rty", m_rty, 4'b0010);
    s_rty = 1'b0; s_ack = 1'b0;
    m_cyc = '0; m_stb = '0; #1;
    check("m1_drop_scyc", s_cyc, 1'b0);
    step;

    // Round robin with all four masters requesting
    rst = 1'b1; step; rst = 1'b0;
    m_cyc = 4'b1111; m_stb = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step;
      check("rr_gnt", gnt, rr_exp[i]);
      check("rr_scyc", s_cyc, 1'b1);
      s_ack = 1'b1; #1;
      check("rr_ack", m_ack, rr_exp[i]);
      s_ack = 1'b0;
      m_cyc = ~rr_exp[i]; m_stb = ~rr_exp[i];
      step;
      check("rr_dead_scyc", s_cyc, 1'b0);
      m_cyc = 4'b1111; m_stb = 4'b1111;
    end
    m_cyc = '0; m_stb = '0;
    step;
    check("rr_hold_gnt", gnt, 4'b0001);

    // Master 0 burst while master 1 waits
    m_cyc = 4'b0001; m_stb = 4'b0001;
    step;
    check("burst_gnt0", gnt, 4'b0001);
    m_cyc = 4'b0011; m_stb = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      m_cti[0 +: 3] = cti_seq[i];
      s_ack = 1'b1; #1;
      check("burst_gnt", gnt, 4'b0001);
      check("burst_ack", m_ack, 4'b0001);
      check("burst_cti", s_cti, cti_seq[i]);
      step;
    end
    s_ack = 1'b0;
    m_cyc = 4'b0010; m_stb = 4'b0010; #1;
    check("burst_drop_scyc", s_cyc, 1'b0);
    step;
    check("burst_idle_gnt", gnt, 4'b0001);
    check("burst_idle_scyc", s_cyc, 1'b0);
    step;
    check("burst_m1_gnt", gnt, 4'b0010);
    check("burst_m1_scyc", s_cyc, 1'b1);

    // No requests: grant must hold at 0100
    m_cyc = '0; m_stb = '0;
    step;
    m_cyc = 4'b0100; m_stb = 4'b0100;
    step;
    check("idle_setup_gnt", gnt, 4'b0100);
    m_cyc = '0; m_stb = '0;
    step;
    for (int i = 0; i < 10; i++) begin
      step;
      check("idle_gnt", gnt, 4'b0100);
      check("idle_scyc", s_cyc, 1'b0);
    end

    // Reset in the middle of a master 1 cycle
    m_cyc = 4'b0010; m_stb = 4'b0010;
    step;
    check("rst_pre_gnt", gnt, 4'b0010);
    s_ack = 1'b1; #1;
    check("rst_pre_ack", m_ack, 4'b0010);
    rst = 1'b1; #1;
    check("rst_scyc", s_cyc, 1'b0);
    check("rst_sstb", s_stb, 1'b0);
    check("rst_ack", m_ack, 4'b0000);
    step;
    check("rst_gnt", gnt, 4'b0001);
    check("rst_hold_ack", m_ack, 4'b0000);
    rst = 1'b0; s_ack = 1'b0; #1;
    check("rst_idle_scyc", s_cyc, 1'b0);
    step;
    check("rst_after_gnt", gnt, 4'b0010);
    check("rst_after_scyc", s_cyc, 1'b1);
    m_cyc = '0; m_stb = '0;
    step;

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never answers: err pulse after 8 stalled cycles, then abort
    m_cyc = 4'b0001; m_stb = 4'b0001;
    step;
    check("to_gnt", gnt, 4'b0001);
    for (int i = 0; i < 8; i++) begin
      check("to_stall_err", m_err, 4'b0000);
      check("to_stall_scyc", s_cyc, 1'b1);
      step;
    end
    check("to_err", m_err, 4'b0001);
    step;
    check("to_abort_err", m_err, 4'b0000);
    check("to_abort_scyc", s_cyc, 1'b0);
    step;
    check("to_abort_scyc2", s_cyc, 1'b0);
    m_cyc = '0; m_stb = '0;
    step;
    m_cyc = 4'b0001; m_stb = 4'b0001;
    step;
    check("to_recover_scyc", s_cyc, 1'b1);
    m_cyc = '0; m_stb = '0;
    step;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
